// File: rtl/tohost_tx_sched.sv
// tohost_tx_sched: decodes tohost words, queues print bytes and paces
// them into UartTx; exit drains the queue, sends a terminator, halts.
module tohost_tx_sched #(
  parameter int unsigned QUEUE_SIZE = 16,
  parameter logic [7:0]  HALT_CHAR  = 8'h04
) (
  input  logic                         CLK,
  input  logic                         RST_X,
  input  logic                         WE,
  input  logic [31:0]                  WDATA,
  input  logic                         TX_READY,
  output logic [7:0]                   TX_DATA,
  output logic                         TX_WE,
  output logic                         FULL,
  output logic [$clog2(QUEUE_SIZE):0]  COUNT,
  output logic [15:0]                  DROP_CNT,
  output logic                         HALTED
);

  localparam int unsigned PW = $clog2(QUEUE_SIZE);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] QS_C = CW'(QUEUE_SIZE);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_BUSY  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [7:0]    mem_q [QUEUE_SIZE];
  logic [2:0]    state_q, state_d;
  logic [PW-1:0] head_q, head_d;
  logic [CW-1:0] count_q, count_d;
  logic          hp_q, hp_d;
  logic          last_q, last_d;
  logic [7:0]    data_q, data_d;
  logic          we_q, we_d;
  logic          halted_q, halted_d;
  logic          full_q, full_d;
  logic [15:0]   drop_q, drop_d;

  logic [1:0]    cmd;
  logic          accept;
  logic          enq;
  logic          drop;
  logic          deq;
  logic [PW-1:0] waddr;
  logic          unused_wdata;

  assign unused_wdata = ^{WDATA[31:18], WDATA[15:8]};

  // Command decode, queue bookkeeping and the send FSM.
  always_comb begin
    cmd      = WDATA[17:16];
    accept   = WE && !hp_q && (state_q != S_DONE);
    enq      = accept && (cmd == 2'd1) && (count_q != QS_C);
    drop     = accept && (cmd == 2'd1) && (count_q == QS_C);
    waddr    = head_q + count_q[PW-1:0];
    deq      = 1'b0;
    state_d  = state_q;
    head_d   = head_q;
    hp_d     = hp_q;
    last_d   = last_q;
    data_d   = data_q;
    if (accept && (cmd == 2'd2)) hp_d = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && TX_READY) begin
          deq     = 1'b1;
          data_d  = mem_q[head_q];
          head_d  = head_q + 1'b1;
          state_d = S_ISSUE;
        end else if (hp_q && TX_READY) begin
          data_d  = HALT_CHAR;
          last_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_GAP;
      S_GAP:   state_d = S_BUSY;
      S_BUSY:  if (TX_READY) state_d = last_q ? S_DONE : S_IDLE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    count_d  = count_q + CW'(enq) - CW'(deq);
    drop_d   = (drop && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
    we_d     = (state_d == S_ISSUE);
    halted_d = (state_d == S_DONE);
    full_d   = (count_d == QS_C);
  end

  // Queue storage; contents need no reset since COUNT gates reads.
  always_ff @(posedge CLK) begin
    if (enq) mem_q[waddr] <= WDATA[7:0];
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state_q  <= S_IDLE;
      head_q   <= '0;
      count_q  <= '0;
      hp_q     <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= '0;
      we_q     <= 1'b0;
      halted_q <= 1'b0;
      full_q   <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      count_q  <= count_d;
      hp_q     <= hp_d;
      last_q   <= last_d;
      data_q   <= data_d;
      we_q     <= we_d;
      halted_q <= halted_d;
      full_q   <= full_d;
      drop_q   <= drop_d;
    end
  end

  assign TX_DATA  = data_q;
  assign TX_WE    = we_q;
  assign FULL     = full_q;
  assign COUNT    = count_q;
  assign DROP_CNT = drop_q;
  assign HALTED   = halted_q;

endmodule
